// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial/parallel converter pair.
package s2p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The transmitter uses the same default so both ends agree on the word size.
  localparam int DEFAULT_DATA_WIDTH = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// One-word valid/ready holding register. A new word is dropped when the register is
// full and not being drained, which raises a one-cycle overflow pulse.
module stream_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word,
  input  logic             word_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             overflow
);

  // Draining and refilling in the same cycle keeps valid high with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      data     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (word_valid) begin
        if (!valid || ready) begin
          data  <= word;
          valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: assembles qualified serial bits into words and
// presents them through a one-word valid/ready holding register.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_din,
  input  logic                  ser_valid,
  output logic [DATA_WIDTH-1:0] par_dout,
  output logic                  par_valid,
  input  logic                  par_ready,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int CNT_W = cnt_w(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic                  word_done;
  logic                  partial_drop;
  logic                  word_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ser_valid) next_state = SHIFT;
      end
      SHIFT: begin
        if (!ser_valid || cnt == LAST_CNT) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A dropped qualifier inside a word discards whatever has been collected so far.
  always_comb begin
    word_done    = (state == SHIFT) && ser_valid && (cnt == LAST_CNT);
    partial_drop = (state == SHIFT) && !ser_valid;
    cnt_next     = cnt;
    shreg_next   = shreg;
    if (word_done || !ser_valid) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
    if (ser_valid) begin
      if (LSB_FIRST != 0) begin
        shreg_next = {ser_din, shreg[DATA_WIDTH-1:1]};
      end else begin
        shreg_next = {shreg[DATA_WIDTH-2:0], ser_din};
      end
    end else if (partial_drop) begin
      shreg_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      shreg       <= '0;
      word_done_q <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      shreg       <= shreg_next;
      word_done_q <= word_done;
      frame_err   <= partial_drop;
    end
  end

  // shreg still holds the finished word during the cycle word_done_q is high,
  // even when the next word's first bit is shifting in at the same edge.
  stream_hold_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .word      (shreg),
    .word_valid(word_done_q),
    .data      (par_dout),
    .valid     (par_valid),
    .ready     (par_ready),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: an LSB-first and an MSB-first instance share one
// serial stream and are compared every cycle against a bit-queue reference model.
module tb_serial_to_parallel;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         ser_din;
  logic         ser_valid;
  logic         par_ready;
  logic [W-1:0] dout_lsb;
  logic         valid_lsb;
  logic         ferr_lsb;
  logic         ovf_lsb;
  logic [W-1:0] dout_msb;
  logic         valid_msb;
  logic         ferr_msb;
  logic         ovf_msb;

  int vectors;
  int miscompares;

  // Reference model state: bits of the word in progress, a completed word on its
  // way to the holding register, and the expected visible outputs.
  bit           m_bits[$];
  bit           m_pend;
  logic [W-1:0] m_pend_l;
  logic [W-1:0] m_pend_m;
  logic [W-1:0] m_dout_l;
  logic [W-1:0] m_dout_m;
  bit           m_valid;
  bit           m_ferr;
  bit           m_ovf;

  serial_to_parallel #(.DATA_WIDTH(W), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .ser_din(ser_din), .ser_valid(ser_valid),
    .par_dout(dout_lsb), .par_valid(valid_lsb), .par_ready(par_ready),
    .frame_err(ferr_lsb), .overflow(ovf_lsb)
  );

  serial_to_parallel #(.DATA_WIDTH(W), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .ser_din(ser_din), .ser_valid(ser_valid),
    .par_dout(dout_msb), .par_valid(valid_msb), .par_ready(par_ready),
    .frame_err(ferr_msb), .overflow(ovf_msb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    if (rst) begin
      m_bits.delete();
      m_pend   = 1'b0;
      m_dout_l = '0;
      m_dout_m = '0;
      m_valid  = 1'b0;
      m_ferr   = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      m_ovf = 1'b0;
      if (m_pend) begin
        if (!m_valid || par_ready) begin
          m_dout_l = m_pend_l;
          m_dout_m = m_pend_m;
          m_valid  = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && par_ready) begin
        m_valid = 1'b0;
      end
      m_pend = 1'b0;
      m_ferr = 1'b0;
      if (ser_valid) begin
        m_bits.push_back(ser_din);
        if (m_bits.size() == W) begin
          m_pend_l = '0;
          m_pend_m = '0;
          foreach (m_bits[i]) begin
            m_pend_l[i]       = m_bits[i];
            m_pend_m[W-1-i]   = m_bits[i];
          end
          m_pend = 1'b1;
          m_bits.delete();
        end
      end else if (m_bits.size() != 0) begin
        m_ferr = 1'b1;
        m_bits.delete();
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit din, input bit v, input bit rdy);
    rst       = r;
    ser_din   = din;
    ser_valid = v;
    par_ready = rdy;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("valid_lsb", {7'b0, valid_lsb}, {7'b0, m_valid});
    checkOutput("dout_lsb",  dout_lsb,          m_dout_l);
    checkOutput("ferr_lsb",  {7'b0, ferr_lsb},  {7'b0, m_ferr});
    checkOutput("ovf_lsb",   {7'b0, ovf_lsb},   {7'b0, m_ovf});
    checkOutput("valid_msb", {7'b0, valid_msb}, {7'b0, m_valid});
    checkOutput("dout_msb",  dout_msb,          m_dout_m);
    checkOutput("ferr_msb",  {7'b0, ferr_msb},  {7'b0, m_ferr});
    checkOutput("ovf_msb",   {7'b0, ovf_msb},   {7'b0, m_ovf});
  endtask

  task automatic sendWord(input logic [W-1:0] w, input bit rdy);
    for (int i = 0; i < W; i++) applyStimulus(1'b0, w[i], 1'b1, rdy);
  endtask

  initial begin
    bit r;
    bit d;
    bit v;
    bit k;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    ser_din     = 1'b0;
    ser_valid   = 1'b0;
    par_ready   = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_dout", dout_lsb, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Single word, word visible one cycle after its last bit.
    sendWord(8'hA5, 1'b1);
    checkOutput("t1_early_valid", {7'b0, valid_lsb}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_valid", {7'b0, valid_lsb}, 8'h01);
    checkOutput("t1_dout", dout_lsb, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_one_cycle", {7'b0, valid_lsb}, 8'h00);

    // Back-to-back words.
    sendWord(8'h3C, 1'b1);
    sendWord(8'hF0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Broken frame followed by a clean word.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_frame_err", {7'b0, ferr_lsb}, 8'h01);
    sendWord(8'h81, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_dout", dout_lsb, 8'h81);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Overflow while the holding register is stalled.
    sendWord(8'h11, 1'b0);
    sendWord(8'h22, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_overflow", {7'b0, ovf_lsb}, 8'h01);
    checkOutput("t4_dout_kept", dout_lsb, 8'h11);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_drained", {7'b0, valid_lsb}, 8'h00);

    // Consume and refill in the same cycle.
    sendWord(8'h11, 1'b0);
    sendWord(8'h22, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_valid", {7'b0, valid_lsb}, 8'h01);
    checkOutput("t5_dout", dout_lsb, 8'h22);
    checkOutput("t5_no_ovf", {7'b0, ovf_lsb}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in mid-word, then a full word in both bit orders.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("t6_rst_ferr", {7'b0, ferr_lsb}, 8'h00);
    sendWord(8'h5A, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_dout_lsb", dout_lsb, 8'h5A);
    checkOutput("t6_dout_msb", dout_msb, 8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with gaps, stalls and occasional resets.
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) != 0);
      d = 1'($urandom_range(0, 1));
      k = ($urandom_range(0, 2) != 0);
      applyStimulus(r, d, v, k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
